// File: rtl/data_mem_mover_pkg.sv
// data_mem_mover_pkg: shared constants and FSM encoding for the block mover.
// Optional checksum output is compiled in with MOVER_CHECKSUM_EN.
package data_mem_mover_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        RD     = 3'd2,
        WR     = 3'd3,
        FINISH = 3'd4
    } state_e;

endpackage

// File: rtl/data_mem_block_mover_if.sv
// data_mem_block_mover_if: word-addressed data memory port.
// Combinational read, posedge write; the mover is the master.
interface data_mem_block_mover_if;
    import data_mem_mover_pkg::*;

    logic [ADDR_W-1:0] mem_Address;
    logic [DATA_W-1:0] mem_WriteData;
    logic              mem_memWrite;
    logic [DATA_W-1:0] mem_ReadData;

    modport master (
        output mem_Address,
        output mem_WriteData,
        output mem_memWrite,
        input  mem_ReadData
    );

    modport slave (
        input  mem_Address,
        input  mem_WriteData,
        input  mem_memWrite,
        output mem_ReadData
    );

endinterface

// File: rtl/mover_addr_gen.sv
// mover_addr_gen: loadable up/down source/destination pointers
// plus the remaining-word counter for one mover command.
module mover_addr_gen
    import data_mem_mover_pkg::*;
#(
    parameter int LEN_W = 11
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              dir_i,
    input  logic [ADDR_W-1:0] src_i,
    input  logic [ADDR_W-1:0] dst_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic [ADDR_W-1:0] src_ptr_o,
    output logic [ADDR_W-1:0] dst_ptr_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              dir_q, dir_d;
    logic [ADDR_W-1:0] span;

    // Offset of the last word; a descending walk starts there.
    assign span = ADDR_W'(len_i) - ADDR_W'(1);

    // Load start pointers or step them one word per write.
    always_comb begin
        src_d = src_q;
        dst_d = dst_q;
        rem_d = rem_q;
        dir_d = dir_q;
        if (load_i) begin
            dir_d = dir_i;
            rem_d = len_i;
            src_d = dir_i ? src_i + span : src_i;
            dst_d = dir_i ? dst_i + span : dst_i;
        end else if (step_i) begin
            rem_d = rem_q - LEN_W'(1);
            src_d = dir_q ? src_q - ADDR_W'(1) : src_q + ADDR_W'(1);
            dst_d = dir_q ? dst_q - ADDR_W'(1) : dst_q + ADDR_W'(1);
        end
    end

    // Pointer and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_q <= '0;
            dst_q <= '0;
            rem_q <= '0;
            dir_q <= 1'b0;
        end else begin
            src_q <= src_d;
            dst_q <= dst_d;
            rem_q <= rem_d;
            dir_q <= dir_d;
        end
    end

    assign src_ptr_o = src_q;
    assign dst_ptr_o = dst_q;
    assign last_o    = (rem_q == LEN_W'(1));

endmodule

// File: rtl/data_mem_block_mover.sv
// data_mem_block_mover: memmove-style block COPY / constant FILL master.
// Define MOVER_CHECKSUM_EN to add the checksum output and its adder.
module data_mem_block_mover
    import data_mem_mover_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int LEN_W = 11
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic [DATA_W-1:0] fill_data,
    output logic              busy,
    output logic              done,
    output logic              err,
`ifdef MOVER_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    data_mem_block_mover_if.master mem
);

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_CHECK  = CHECK;
    localparam logic [2:0] S_RD     = RD;
    localparam logic [2:0] S_WR     = WR;
    localparam logic [2:0] S_FINISH = FINISH;

    localparam logic [ADDR_W:0] LIMIT = {1'b0, ADDR_W'(DEPTH)};

    logic [2:0]        state_q, state_d;
    logic              mode_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  len_q;
    logic [DATA_W-1:0] fill_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic              accept;
    logic              dir;
    logic              range_err;
    logic [ADDR_W:0]   src_end;
    logic [ADDR_W:0]   dst_end;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic              last;
    logic              st_rd;
    logic              st_wr;
    logic [DATA_W-1:0] wdata;

    assign accept = (state_q == S_IDLE) && start;
    assign st_rd  = (state_q == S_RD);
    assign st_wr  = (state_q == S_WR);

    // Descend only for a copy whose destination is above the source.
    assign dir = (mode == MODE_COPY) && (dst_addr > src_addr);

    // One bit wider than an address so the end sums cannot wrap.
    assign src_end = {1'b0, src_q} + {1'b0, ADDR_W'(len_q)};
    assign dst_end = {1'b0, dst_q} + {1'b0, ADDR_W'(len_q)};

    assign range_err = (dst_end > LIMIT) ||
                       ((mode_q == MODE_COPY) && (src_end > LIMIT));

    assign wdata = (mode_q == MODE_FILL) ? fill_q : rdata_q;

    mover_addr_gen #(
        .LEN_W (LEN_W)
    ) u_addr_gen (
        .clk_i     (Clk),
        .rst_ni    (Rst),
        .load_i    (accept),
        .step_i    (st_wr),
        .dir_i     (dir),
        .src_i     (src_addr),
        .dst_i     (dst_addr),
        .len_i     (length),
        .src_ptr_o (src_ptr),
        .dst_ptr_o (dst_ptr),
        .last_o    (last)
    );

    // Next-state logic for the command sequencer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (range_err || (len_q == '0)) state_d = S_FINISH;
                else if (mode_q == MODE_COPY)   state_d = S_RD;
                else                            state_d = S_WR;
            end
            S_RD: begin
                state_d = S_WR;
            end
            S_WR: begin
                if (last)                     state_d = S_FINISH;
                else if (mode_q == MODE_COPY) state_d = S_RD;
                else                          state_d = S_WR;
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, latched command, read capture and error flag.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_COPY;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            fill_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                mode_q <= mode;
                src_q  <= src_addr;
                dst_q  <= dst_addr;
                len_q  <= length;
                fill_q <= fill_data;
                err_q  <= 1'b0;
            end
            if ((state_q == S_CHECK) && range_err) begin
                err_q <= 1'b1;
            end
            if (st_rd) begin
                rdata_q <= mem.mem_ReadData;
            end
        end
    end

`ifdef MOVER_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    // Running sum of the words written by the current command.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            csum_q <= '0;
        end else if (accept) begin
            csum_q <= '0;
        end else if (st_wr) begin
            csum_q <= csum_q + wdata;
        end
    end

    assign checksum = csum_q;
`endif

    // Memory pins decoded from state and registered pointers only.
    always_comb begin
        mem.mem_Address   = '0;
        mem.mem_WriteData = '0;
        mem.mem_memWrite  = 1'b0;
        unique case (1'b1)
            st_rd: begin
                mem.mem_Address = src_ptr;
            end
            st_wr: begin
                mem.mem_Address   = dst_ptr;
                mem.mem_WriteData = wdata;
                mem.mem_memWrite  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_FINISH);
    assign err  = err_q;

endmodule

// File: tb/tb_data_mem_block_mover.sv
// tb_data_mem_block_mover: directed and random commands against
// a memmove/fill reference built from whole-block arithmetic.
`timescale 1ns/1ps
module tb_data_mem_block_mover;
    import data_mem_mover_pkg::*;

    localparam int DEPTH = 1024;
    localparam int LEN_W = 11;

    logic              Clk = 1'b0;
    logic              Rst = 1'b0;
    logic              start = 1'b0;
    logic              mode = 1'b0;
    logic [31:0]       src_addr = '0;
    logic [31:0]       dst_addr = '0;
    logic [LEN_W-1:0]  length = '0;
    logic [31:0]       fill_data = '0;
    logic              busy;
    logic              done;
    logic              err;
`ifdef MOVER_CHECKSUM_EN
    logic [31:0]       checksum;
`endif

    logic [31:0] mem  [DEPTH];
    logic [31:0] mexp [DEPTH];
    int n_chk = 0;
    int n_pass = 0;

    data_mem_block_mover_if mif();

    always #5 Clk = ~Clk;

    assign mif.mem_ReadData = (mif.mem_Address < 32'(DEPTH)) ?
                              mem[mif.mem_Address[9:0]] : 32'h0;

    data_mem_block_mover #(
        .DEPTH (DEPTH),
        .LEN_W (LEN_W)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .start     (start),
        .mode      (mode),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .length    (length),
        .fill_data (fill_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
`ifdef MOVER_CHECKSUM_EN
        .checksum  (checksum),
`endif
        .mem       (mif)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Issue one command, mirror its writes into mem, compare with model.
    task automatic run_cmd(input logic m, input int s, input int d,
                           input int len, input logic [31:0] fv,
                           input bit poke);
        int ws[$];
        int rs[$];
        int exp_w[$];
        int exp_r[$];
        logic [31:0] blk[$];
        bit e_err;
        bit desc;
        int e_done;
        int lbl;
        int done_at;
        int n_done;
        int nbad;
        int extra_we;
        logic prev_we;
        logic [31:0] prev_addr;
        logic [31:0] sum;

        for (int i = 0; i < DEPTH; i++) mexp[i] = mem[i];
        e_err = (longint'(d) + len > DEPTH) ||
                (m == MODE_COPY && longint'(s) + len > DEPTH);
        desc = (m == MODE_COPY) && (d > s);
        sum = 0;
        if (!e_err) begin
            for (int i = 0; i < len; i++)
                blk.push_back(m == MODE_FILL ? fv : mem[s + i]);
            for (int i = 0; i < len; i++) begin
                mexp[d + i] = blk[i];
                sum += blk[i];
            end
            for (int k = 0; k < len; k++) begin
                int i;
                i = desc ? len - 1 - k : k;
                exp_w.push_back(d + i);
                if (m == MODE_COPY) exp_r.push_back(s + i);
            end
        end
        if (e_err || len == 0) e_done = 2;
        else if (m == MODE_FILL) e_done = len + 2;
        else e_done = 2 * len + 2;

        @(negedge Clk);
        mode = m;
        src_addr = 32'(s);
        dst_addr = 32'(d);
        length = LEN_W'(len);
        fill_data = fv;
        start = 1'b1;
        lbl = 0;
        done_at = 0;
        prev_we = 1'b0;
        prev_addr = '0;
        while (done_at == 0 && lbl < 3000) begin
            @(negedge Clk);
            lbl++;
            start = poke && (lbl == 1);
            if (poke && lbl == 1) begin
                mode = MODE_FILL;
                dst_addr = 32'd700;
                length = LEN_W'(5);
            end
            if (lbl == 1) chk("busy_on", 32'(busy), 32'd1);
            if (mif.mem_memWrite) begin
                ws.push_back(int'(mif.mem_Address));
                if (m == MODE_COPY)
                    rs.push_back(prev_we ? -1 : int'(prev_addr));
                if (mif.mem_Address < 32'(DEPTH))
                    mem[mif.mem_Address[9:0]] = mif.mem_WriteData;
            end
            prev_we = mif.mem_memWrite;
            prev_addr = mif.mem_Address;
            if (done) done_at = lbl;
        end
        start = 1'b0;
        if (done_at == 0) chk("timeout", 32'd0, 32'd1);

        chk("err", 32'(err), 32'(e_err));
        chk("done_cyc", 32'(done_at), 32'(e_done));
        chk("n_writes", 32'(ws.size()), 32'(exp_w.size()));
        nbad = 0;
        for (int k = 0; k < ws.size() && k < exp_w.size(); k++)
            if (ws[k] != exp_w[k]) nbad++;
        for (int k = 0; k < rs.size() && k < exp_r.size(); k++)
            if (rs[k] != exp_r[k]) nbad++;
        chk("order", 32'(nbad), 32'd0);
        nbad = 0;
        for (int i = 0; i < DEPTH; i++)
            if (mem[i] !== mexp[i]) nbad++;
        chk("mem", 32'(nbad), 32'd0);
`ifdef MOVER_CHECKSUM_EN
        chk("csum", checksum, e_err ? 32'd0 : sum);
`endif

        n_done = 0;
        extra_we = 0;
        repeat (3) begin
            @(negedge Clk);
            if (done) n_done++;
            if (mif.mem_memWrite) extra_we++;
        end
        chk("extra_done", 32'(n_done), 32'd0);
        chk("extra_we", 32'(extra_we), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;

        repeat (2) @(negedge Clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_we", 32'(mif.mem_memWrite), 32'd0);
        chk("rst_addr", mif.mem_Address, 32'd0);
        chk("rst_wdata", mif.mem_WriteData, 32'd0);
        Rst = 1'b1;
        @(negedge Clk);

        run_cmd(MODE_FILL, 0, 100, 4, 32'hDEADBEEF, 1'b0);
        chk("fill_100", mem[100], 32'hDEADBEEF);
        chk("fill_103", mem[103], 32'hDEADBEEF);

        mem[0] = 32'd1;
        mem[1] = 32'd2;
        mem[2] = 32'd3;
        run_cmd(MODE_COPY, 0, 512, 3, 32'd0, 1'b0);
        chk("copy_512", mem[512], 32'd1);
        chk("copy_514", mem[514], 32'd3);

        mem[10] = 32'hA;
        mem[11] = 32'hB;
        mem[12] = 32'hC;
        mem[13] = 32'hD;
        run_cmd(MODE_COPY, 10, 12, 4, 32'd0, 1'b0);
        chk("ovl_12", mem[12], 32'hA);
        chk("ovl_15", mem[15], 32'hD);

        run_cmd(MODE_COPY, 1022, 0, 4, 32'd0, 1'b0);
        run_cmd(MODE_FILL, 0, 1020, 5, 32'h1, 1'b0);
        run_cmd(MODE_FILL, 0, 50, 0, 32'h77, 1'b1);
        run_cmd(MODE_COPY, 300, 40, 3, 32'd0, 1'b1);
        run_cmd(MODE_FILL, 0, 600, 4, 32'd5, 1'b0);
`ifdef MOVER_CHECKSUM_EN
        chk("csum_20", checksum, 32'd20);
`endif

        @(negedge Clk);
        mode = MODE_FILL;
        dst_addr = 32'd200;
        length = LEN_W'(16);
        fill_data = 32'h55AA55AA;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        repeat (3) @(negedge Clk);
        chk("pre_rst_we", 32'(mif.mem_memWrite), 32'd1);
        #2 Rst = 1'b0;
        #1;
        chk("arst_we", 32'(mif.mem_memWrite), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_addr", mif.mem_Address, 32'd0);
        @(negedge Clk);
        Rst = 1'b1;
        run_cmd(MODE_FILL, 0, 300, 1, 32'h12345678, 1'b0);
        chk("post_rst", mem[300], 32'h12345678);

        for (int t = 0; t < 40; t++) begin
            int s;
            int d;
            int len;
            logic m;
            m = 1'($urandom_range(0, 1));
            s = int'($urandom_range(0, 1030));
            len = int'($urandom_range(0, 16));
            if ($urandom_range(0, 1) == 1)
                d = s + int'($urandom_range(0, 8)) - 4;
            else
                d = int'($urandom_range(0, 1030));
            if (d < 0) d = 0;
            run_cmd(m, s, d, len, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
